// File: rtl/rr_grant_pkg.sv
// Shared types and helpers for the round-robin grant controller and its picker.
package rr_grant_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int CNT_W = 8;

    // Index width that never collapses to zero for a single-entry range.
    function automatic int clog2_min1(input int n);
        return (n <= 32'sd2) ? 32'sd1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: first set request scanning upward from ptr with wrap.
module rr_pick #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] winner,
    output logic         valid
);

    logic [2*N-1:0] dbl_s;
    logic [N-1:0]   rot_s;

    // Rotate so that bit 0 of rot_s is the request at ptr.
    always_comb begin
        dbl_s = {req, req} >> ptr;
        rot_s = dbl_s[N-1:0];
    end

    // Scan the rotated vector and map the first hit back to an absolute index.
    always_comb begin
        logic [W:0] sum_v;
        winner = '0;
        valid  = 1'b0;
        sum_v  = '0;
        for (int i = 0; i < N; i++) begin
            sum_v  = {1'b0, ptr} + (W+1)'(i);
            sum_v  = (sum_v >= (W+1)'(N)) ? (sum_v - (W+1)'(N)) : sum_v;
            winner = (rot_s[i] && !valid) ? sum_v[W-1:0] : winner;
            valid  = valid | rot_s[i];
        end
    end

endmodule

// File: rtl/rr_grant_ctrl.sv
// Round-robin ownership controller: registered one-hot grant held for a multi-beat
// transfer, released on last, beat cap, stall watchdog or request abort.
module rr_grant_ctrl
    import rr_grant_pkg::*;
#(
    parameter int N           = 2,
    parameter int MAX_BEATS   = 8,
    parameter int STALL_LIMIT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N-1:0]             req,
    input  logic [N-1:0]             last,
    input  logic                     beat,
    output logic [N-1:0]             grant,
    output logic                     busy,
    output logic [clog2_min1(N)-1:0] owner_id,
    output logic                     stall_err,
    output logic                     cut_evt
);

    localparam int W = clog2_min1(N);
    localparam logic [CNT_W-1:0] BEAT_END  = CNT_W'(MAX_BEATS - 1);
    localparam logic [CNT_W-1:0] STALL_END = CNT_W'(STALL_LIMIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_r, state_s;
    logic [W-1:0]     ptr_r, ptr_s;
    logic [CNT_W-1:0] beat_cnt_r, beat_cnt_s;
    logic [CNT_W-1:0] stall_cnt_r, stall_cnt_s;
    logic [N-1:0]     grant_r, grant_s;
    logic [W-1:0]     owner_r, owner_s;
    logic             busy_r, busy_s;
    logic             stall_err_r, stall_err_s;
    logic             cut_evt_r, cut_evt_s;
    logic             leave_s;
    logic [W-1:0]     pick_winner_s;
    logic             pick_valid_s;

    rr_pick #(.N(N), .W(W)) u_pick (
        .req    (req),
        .ptr    (ptr_r),
        .winner (pick_winner_s),
        .valid  (pick_valid_s)
    );

    // Next-state, counter and output decode; exit conditions in OWN are prioritised.
    always_comb begin
        state_s     = state_r;
        ptr_s       = ptr_r;
        beat_cnt_s  = beat_cnt_r;
        stall_cnt_s = stall_cnt_r;
        grant_s     = grant_r;
        owner_s     = owner_r;
        stall_err_s = 1'b0;
        cut_evt_s   = 1'b0;
        leave_s     = 1'b0;
        case (state_r)
            IDLE: begin
                beat_cnt_s  = '0;
                stall_cnt_s = '0;
                if (pick_valid_s) begin
                    state_s = OWN;
                    grant_s = {{(N-1){1'b0}}, 1'b1} << pick_winner_s;
                    owner_s = pick_winner_s;
                end else begin
                    state_s = IDLE;
                    grant_s = '0;
                end
            end
            OWN: begin
                if (!req[owner_r]) begin
                    leave_s = 1'b1;
                end else if (beat && last[owner_r]) begin
                    leave_s = 1'b1;
                end else if (beat && (beat_cnt_r == BEAT_END)) begin
                    leave_s   = 1'b1;
                    cut_evt_s = 1'b1;
                end else if (!beat && (stall_cnt_r == STALL_END)) begin
                    leave_s     = 1'b1;
                    stall_err_s = 1'b1;
                end else if (beat) begin
                    beat_cnt_s  = beat_cnt_r + CNT_ONE;
                    stall_cnt_s = '0;
                end else begin
                    stall_cnt_s = stall_cnt_r + CNT_ONE;
                end
                // The departing owner becomes lowest priority for the next pick.
                if (leave_s) begin
                    state_s = GAP;
                    grant_s = '0;
                    ptr_s   = (owner_r == W'(N - 1)) ? '0 : (owner_r + W'(1'b1));
                end else begin
                    state_s = OWN;
                end
            end
            GAP: begin
                state_s     = IDLE;
                grant_s     = '0;
                beat_cnt_s  = '0;
                stall_cnt_s = '0;
            end
            default: begin
                state_s     = IDLE;
                grant_s     = '0;
                beat_cnt_s  = '0;
                stall_cnt_s = '0;
            end
        endcase
        busy_s = (state_s == OWN);
    end

    // State, pointer, counters and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            ptr_r       <= '0;
            beat_cnt_r  <= '0;
            stall_cnt_r <= '0;
            grant_r     <= '0;
            owner_r     <= '0;
            busy_r      <= 1'b0;
            stall_err_r <= 1'b0;
            cut_evt_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            ptr_r       <= ptr_s;
            beat_cnt_r  <= beat_cnt_s;
            stall_cnt_r <= stall_cnt_s;
            grant_r     <= grant_s;
            owner_r     <= owner_s;
            busy_r      <= busy_s;
            stall_err_r <= stall_err_s;
            cut_evt_r   <= cut_evt_s;
        end
    end

    assign grant     = grant_r;
    assign busy      = busy_r;
    assign owner_id  = owner_r;
    assign stall_err = stall_err_r;
    assign cut_evt   = cut_evt_r;

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Self-checking bench for rr_grant_ctrl (N=4, MAX_BEATS=8, STALL_LIMIT=16).
module tb_rr_grant_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] last;
    logic       beat;
    logic [3:0] grant;
    logic       busy;
    logic [1:0] owner_id;
    logic       stall_err;
    logic       cut_evt;

    int total;
    int bad;

    logic [8:0] exp_q[$];

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       beat;
        logic [3:0] last;
        logic [3:0] grant;
        logic       busy;
        logic [1:0] owner;
        logic       stall;
        logic       cut;
    } vec_t;

    vec_t vecs[18];

    rr_grant_ctrl #(.N(4), .MAX_BEATS(8), .STALL_LIMIT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .last      (last),
        .beat      (beat),
        .grant     (grant),
        .busy      (busy),
        .owner_id  (owner_id),
        .stall_err (stall_err),
        .cut_evt   (cut_evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus, queue its expectation, then check after the edge.
    task automatic step(input string name, input logic r, input logic [3:0] rq,
                        input logic bt, input logic [3:0] ls, input logic [3:0] eg,
                        input logic eb, input logic [1:0] eo, input logic es, input logic ec);
        logic [8:0] e;
        logic [8:0] a;
        rst  = r;
        req  = rq;
        beat = bt;
        last = ls;
        exp_q.push_back({eg, eb, eo, es, ec});
        @(posedge clk);
        #1;
        a = {grant, busy, owner_id, stall_err, cut_evt};
        e = exp_q.pop_front();
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got grant=%b busy=%b owner=%0d stall=%b cut=%b, want grant=%b busy=%b owner=%0d stall=%b cut=%b",
                     name, a[8:5], a[4], a[3:2], a[1], a[0], e[8:5], e[4], e[3:2], e[1], e[0]);
        end
    endtask

    initial begin
        logic [3:0] oh;
        int n;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        req   = 4'b0000;
        beat  = 1'b0;
        last  = 4'b0000;

        // Rotation table: reset, then owners 0,1,2,3,0 each with two beats.
        vecs[0] = '{1'b1, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0};
        n = 1;
        for (int k = 0; k < 4; k++) begin
            oh = 4'b0001 << k;
            vecs[n]   = '{1'b0, 4'b1111, 1'b0, 4'b0000, oh,      1'b1, 2'(k), 1'b0, 1'b0};
            vecs[n+1] = '{1'b0, 4'b1111, 1'b1, ~oh,     oh,      1'b1, 2'(k), 1'b0, 1'b0};
            vecs[n+2] = '{1'b0, 4'b1111, 1'b1, oh,      4'b0000, 1'b0, 2'(k), 1'b0, 1'b0};
            vecs[n+3] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'(k), 1'b0, 1'b0};
            n = n + 4;
        end
        vecs[17] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0, 1'b0};

        // Reset held with requests pending, first grant, then reset mid-ownership.
        step("rst_hold0",   1'b1, 4'b0011, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
        step("rst_hold1",   1'b1, 4'b0011, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
        step("first_grant", 1'b0, 4'b0011, 1'b0, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0, 1'b0);
        step("last_rel",    1'b0, 4'b0011, 1'b1, 4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
        step("last_gap",    1'b0, 4'b0011, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
        step("grant_1",     1'b0, 4'b0011, 1'b0, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b0, 1'b0);
        step("mid_rst",     1'b1, 4'b0011, 1'b1, 4'b0010, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
        step("post_rst",    1'b0, 4'b0011, 1'b1, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0, 1'b0);

        // Beat cap: eight beats without last end the grant with cut_evt.
        for (int i = 0; i < 7; i++)
            step("cap_run", 1'b0, 4'b0011, 1'b1, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0, 1'b0);
        step("cap_cut",     1'b0, 4'b0011, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b1);
        step("cap_gap",     1'b0, 4'b0011, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
        step("cap_next",    1'b0, 4'b0011, 1'b0, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b0, 1'b0);

        // Stall watchdog: sixteen idle cycles reclaim the port, ptr moves to 2.
        for (int i = 0; i < 15; i++)
            step("stall_wait", 1'b0, 4'b0011, 1'b0, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b0, 1'b0);
        step("stall_err",   1'b0, 4'b0011, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd1, 1'b1, 1'b0);
        step("stall_gap",   1'b0, 4'b0111, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd1, 1'b0, 1'b0);
        step("stall_next",  1'b0, 4'b0111, 1'b0, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b0, 1'b0);

        // A beat clears the stall count; then abort coinciding with beat+last.
        for (int i = 0; i < 10; i++)
            step("hold_a", 1'b0, 4'b0111, 1'b0, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b0, 1'b0);
        step("hold_beat1",  1'b0, 4'b0111, 1'b1, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++)
            step("hold_b", 1'b0, 4'b0111, 1'b0, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b0, 1'b0);
        step("hold_beat2",  1'b0, 4'b0111, 1'b1, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b0, 1'b0);
        step("hold_beat3",  1'b0, 4'b0111, 1'b1, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b0, 1'b0);
        step("abort",       1'b0, 4'b0011, 1'b1, 4'b0100, 4'b0000, 1'b0, 2'd2, 1'b0, 1'b0);
        step("abort_gap",   1'b0, 4'b0011, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b0, 1'b0);
        step("abort_next",  1'b0, 4'b0011, 1'b0, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0, 1'b0);

        // Last on the cap beat is a normal release without cut_evt.
        for (int i = 0; i < 7; i++)
            step("caplast_run", 1'b0, 4'b0011, 1'b1, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0, 1'b0);
        step("cap_last",    1'b0, 4'b0011, 1'b1, 4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
        step("idle_gap",    1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
        step("idle_noreq",  1'b0, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);

        for (int i = 0; i < 18; i++)
            step($sformatf("rot_%0d", i), vecs[i].rst, vecs[i].req, vecs[i].beat, vecs[i].last,
                 vecs[i].grant, vecs[i].busy, vecs[i].owner, vecs[i].stall, vecs[i].cut);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
